mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
- Scan sequencer for the 10:1 select path.
- Drives the 4-bit select of the 10x1 mux through channels 0..9 and waits a programmable settle time per channel.
- Samples the mux output for each channel and packs the ten samples into one 10-bit word.
- Presents the word downstream on a valid/ready handshake; sits directly upstream (select) and downstream (data) of the mux.

Parameters:
- NUM_CH, 10, number of channels scanned (2..16); channel k maps to sel value k.
- SEL_W, 4, select width; must satisfy 2**SEL_W >= NUM_CH.
- SETTLE, 2, cycles sel is held stable before sampling (>= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request one scan; sampled only in IDLE.
- cont  input  1  continuous mode; sampled at each output handshake.
- abort  input  1  synchronous abort; returns to IDLE from any state.
- mux_y  input  1  output of the 10x1 mux.
- sel  output  SEL_W  registered select to the mux.
- out_data  output  NUM_CH  packed samples; bit k = mux_y sampled with sel==k.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accept.
- busy  output  1  high in SETTLE or HOLD.

Behaviour:
- Reset (async, rst_n low): sel=0, out_data=0, out_valid=0, busy=0, internal shadow=0, cnt=0, state IDLE.
- States: IDLE, SETTLE, HOLD.
- IDLE:
  - sel held at 0, busy=0.
  - start=1 -> SETTLE, sel<=0, cnt<=0, shadow<=0.
- SETTLE:
  - busy=1; cnt increments each cycle.
  - On the edge where cnt==SETTLE-1: shadow[sel]<=mux_y and cnt<=0.
  - If sel!=NUM_CH-1: sel<=sel+1, stay in SETTLE.
  - If sel==NUM_CH-1: out_data<={mux_y, shadow[NUM_CH-2:0]}, out_valid<=1, sel<=0, go to HOLD.
- Timing:
  - Each channel occupies exactly SETTLE cycles.
  - A full scan is NUM_CH*SETTLE cycles from the start-accept edge to the out_valid-rise edge.
  - Defaults: 20 cycles.
- HOLD:
  - out_valid=1; out_data stable until handshake.
  - sel stays 0; mux_y is ignored.
- Handshake (out_valid & out_ready at a rising edge):
  - out_valid<=0.
  - cont=1 -> SETTLE with cnt<=0, shadow<=0. The next scan begins with no idle cycle.
  - cont=0 -> IDLE.
- out_ready low in HOLD: stall indefinitely; no data loss or change.
- start in SETTLE/HOLD: ignored; not queued.
- abort=1 in any state: next edge -> IDLE, sel<=0, cnt<=0, out_valid<=0. out_data keeps its last value. abort dominates start and the handshake in the same cycle.
- rst_n asserted mid-scan: immediate return to reset values; partial shadow is discarded.
- sel never exceeds NUM_CH-1; unused sel codes are never driven.
- cnt width is clog2(SETTLE)+1. The SETTLE=1 case samples on every cycle.

Optional Feature:
- Macro MUX_SCAN_PARITY_EN.
- Defined:
  - Extra output out_par (1 bit), reset 0.
  - Registered together with out_data on the HOLD-entry edge as even parity (XOR of all NUM_CH bits of the new word).
  - Held with out_data; unaffected by abort.
- Undefined: out_par port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then single scan, SETTLE=2, mux model returns i[sel] with i=10'b1011001110, start pulse, out_ready=1:
  - sel steps 0..9, each held 2 cycles.
  - out_valid rises 20 cycles after the start edge with out_data=10'b1011001110.
  - Returns to IDLE.
- Backpressure: same scan with out_ready=0 for 7 cycles after out_valid:
  - out_valid and out_data stay stable.
  - Accept on cycle 8; out_valid drops the next cycle.
- Continuous: cont=1, i changes to 10'h155 between scans:
  - Second word is 10'h155.
  - sel=0 SETTLE begins on the cycle after the handshake, with no IDLE gap.
- Abort mid-scan at sel=5:
  - Next cycle: IDLE, sel=0, out_valid=0, busy=0.
  - A following start produces a full, correct word.
- Async reset during HOLD: rst_n low between edges -> out_valid, out_data, sel, busy read 0 immediately.
- With MUX_SCAN_PARITY_EN: word 10'b1011001110 -> out_par=0; word 10'b0000000111 -> out_par=1.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for the NUM_CH:1 select path: steps sel, samples mux_y per channel, emits a packed word.
// Optional even-parity output out_par enabled by defining MUX_SCAN_PARITY_EN.
module mux_scan_ctrl #(
    parameter int unsigned NUM_CH = 10,
    parameter int unsigned SEL_W  = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont,
    input  logic              abort,
    input  logic              mux_y,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic              out_par
`endif
);

    localparam int unsigned CNT_W = $clog2(SETTLE) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_HOLD
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    // The last channel goes straight into out_data, so only NUM_CH-1 samples are shadowed.
    logic [NUM_CH-2:0]   shadow;
    logic [NUM_CH-1:0]   word_c;

    assign word_c = {mux_y, shadow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sel       <= '0;
            cnt       <= '0;
            shadow    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            out_par   <= 1'b0;
`endif
        end else if (abort) begin
            state     <= S_IDLE;
            sel       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_SETTLE;
                        sel    <= '0;
                        cnt    <= '0;
                        shadow <= '0;
                        busy   <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (sel == SEL_LAST) begin
                            out_data  <= word_c;
                            out_valid <= 1'b1;
                            sel       <= '0;
                            state     <= S_HOLD;
`ifdef MUX_SCAN_PARITY_EN
                            out_par   <= ^word_c;
`endif
                        end else begin
                            shadow[sel] <= mux_y;
                            sel         <= sel + SEL_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    // Continuous mode restarts at channel 0 on the handshake edge itself.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (cont) begin
                            state  <= S_SETTLE;
                            cnt    <= '0;
                            shadow <= '0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl (NUM_CH=10, SEL_W=4, SETTLE=2) with a behavioural 10:1 mux model.
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       cont;
    logic       abort;
    logic       mux_y;
    logic [3:0] sel;
    logic [9:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
`ifdef MUX_SCAN_PARITY_EN
    logic       out_par;
`endif

    logic [9:0] pat;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [9:0] pat;
        int         stall;
        logic       hold_start;
        logic [9:0] exp_word;
        logic       exp_par;
    } vec_t;

    vec_t vecs[6];

    mux_scan_ctrl #(.NUM_CH(10), .SEL_W(4), .SETTLE(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cont      (cont),
        .abort     (abort),
        .mux_y     (mux_y),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 10:1 mux model; unused select codes read back as 0
    always_comb begin
        mux_y = 1'b0;
        if (sel < 4'd10) mux_y = pat[sel];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse start; returns 1 ns after the accept edge.
    task automatic start_scan(input logic hold_start);
        start = 1'b1;
        @(posedge clk); #1;
        start = hold_start;
        check("accept_busy", int'(busy), 1);
        check("accept_sel", int'(sel), 0);
    endtask

    // Called 1 ns after the scan's first edge; returns 1 ns after the handshake edge.
    task automatic scan_body(input logic [9:0] exp_word, input logic exp_par,
                             input int stall, input logic c);
        int bad;
        cont      = c;
        out_ready = 1'b0;
        bad = 0;
        for (int k = 1; k < 20; k++) begin
            @(posedge clk); #1;
            if (sel != 4'(k / 2) || out_valid || !busy) bad++;
        end
        check("scan_seq", bad, 0);
        @(posedge clk); #1;
        check("valid_rise", int'(out_valid), 1);
        check("word", int'(out_data), int'(exp_word));
        check("busy_hold", int'(busy), 1);
`ifdef MUX_SCAN_PARITY_EN
        check("parity", int'(out_par), int'(exp_par));
`endif
        bad = 0;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            if (!out_valid || out_data != exp_word || sel != 4'd0 || !busy) bad++;
        end
        check("stall_stable", bad, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop", int'(out_valid), 0);
        check("busy_after", int'(busy), int'(c));
        check("sel_after", int'(sel), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        cont      = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        pat       = 10'h0;

        vecs[0] = '{10'b1011001110, 0, 1'b0, 10'b1011001110, 1'b0};
        vecs[1] = '{10'b1011001110, 7, 1'b0, 10'b1011001110, 1'b0};
        vecs[2] = '{10'b0000000111, 2, 1'b1, 10'b0000000111, 1'b1};
        vecs[3] = '{10'h3FF,        0, 1'b0, 10'h3FF,        1'b0};
        vecs[4] = '{10'h000,        1, 1'b0, 10'h000,        1'b0};
        vecs[5] = '{10'b1000000001, 0, 1'b0, 10'b1000000001, 1'b0};

        #2;
        check("rst_sel", int'(sel), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", int'(busy), 0);

        for (int i = 0; i < 6; i++) begin
            pat = vecs[i].pat;
            start_scan(vecs[i].hold_start);
            scan_body(vecs[i].exp_word, vecs[i].exp_par, vecs[i].stall, 1'b0);
            start = 1'b0;
            @(posedge clk); #1;
            check("back_idle", int'(busy), 0);
        end

        // Continuous mode: second scan starts on the handshake edge with a new pattern
        pat = 10'b1011001110;
        start_scan(1'b0);
        scan_body(10'b1011001110, 1'b0, 0, 1'b1);
        pat = 10'h155;
        scan_body(10'h155, 1'b1, 0, 1'b0);

        // Abort mid-scan while sel==5
        pat = 10'h2AA;
        start_scan(1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("pre_abort_sel", int'(sel), 5);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_sel", int'(sel), 0);
        check("abort_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_keep_data", int'(out_data), 'h155);
        @(posedge clk); #1;
        check("abort_stays_idle", int'(busy), 0);
        start_scan(1'b0);
        scan_body(10'h2AA, 1'b1, 0, 1'b0);

        // Abort in HOLD beats a simultaneous continuous handshake
        pat = 10'h0E0;
        start_scan(1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("hold_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        cont      = 1'b1;
        abort     = 1'b1;
        @(posedge clk); #1;
        abort     = 1'b0;
        out_ready = 1'b0;
        cont      = 1'b0;
        check("abort_hs_valid", int'(out_valid), 0);
        check("abort_hs_busy", int'(busy), 0);
        check("abort_hs_data", int'(out_data), 'h0E0);
`ifdef MUX_SCAN_PARITY_EN
        check("abort_hs_par", int'(out_par), 1);
`endif
        @(posedge clk); #1;
        check("abort_hs_idle", int'(busy), 0);

        // Asynchronous reset between edges while in HOLD
        pat = 10'h3C5;
        start_scan(1'b0);
        repeat (20) @(posedge clk);
        #2;
        check("pre_rst_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", int'(out_valid), 0);
        check("arst_data", int'(out_data), 0);
        check("arst_sel", int'(sel), 0);
        check("arst_busy", int'(busy), 0);
`ifdef MUX_SCAN_PARITY_EN
        check("arst_par", int'(out_par), 0);
`endif
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
